// File: rtl/arith_seq.sv
// arith_seq: parametrised local program sequencer issuing au micro-operation pulses and tracking A/B/C signs
module arith_seq #(
  parameter int WIDTH = 30,
  parameter int IO_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_a_from_pu,
  input  logic            move_b_to_c_from_pu,
  input  logic            move_c_to_b_from_pu,
  input  logic            move_c_to_a_from_pu,
  input  logic            order_add_from_op,
  input  logic            order_sub_from_op,
  input  logic            order_mul_from_op,
  input  logic            order_div_from_op,
  input  logic            order_and_from_op,
  input  logic            order_io_from_io,
  input  logic [IO_W-1:0] io_digits_from_io,
  input  logic            io_c29_from_io,
  input  logic            ctrl_abs_from_op,
  input  logic            read_sign_from_mem,
  input  logic            arr_reg_c_sign_from_pnl,
  input  logic            do_read_mem_from_mem,
  input  logic            do_arr_c_from_pnl,
  input  logic            carry_out_from_au,
  input  logic            reg_c1_from_au,
  input  logic            reg_c_lsb_from_au,
  input  logic            reg_b0_from_au,
  output logic            au_answer_to_op,
  output logic            overflow_to_op,
  output logic            order_error_to_op,
  output logic            au_busy_to_op,
  output logic            do_clear_a_to_au,
  output logic            do_clear_b_to_au,
  output logic            do_not_a_to_au,
  output logic            do_not_b_to_au,
  output logic            do_sum_to_au,
  output logic            do_and_to_au,
  output logic            do_set_c_lsb_to_au,
  output logic            do_left_shift_b_to_au,
  output logic            do_left_shift_c_to_au,
  output logic            do_left_shift_c29_to_au,
  output logic            do_right_shift_bc_to_au,
  output logic            do_move_c_to_a_to_au,
  output logic            do_move_c_to_b_to_au,
  output logic            do_move_b_to_c_to_au,
  output logic            reg_a_sign_to_op,
  output logic            reg_b_sign_to_op,
  output logic            reg_b_sign_to_pu,
  output logic            write_sign_to_mem,
  output logic            output_sign_to_io
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [4:0] {
    IDLE, ADD_SUM, ADD_MV, SUB_NOT, SUB_CHK, SUB_FIX, SUB_MV,
    MUL_INIT, MUL_ADD, MUL_SHR, MUL_MV, DIV_INIT, DIV_CHK, DIV_SHL, DIV_SUM, DIV_MV,
    AND_DO, AND_MV, IO_SH, IO_DONE
  } state_t;
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IO_W-1:0] n_q, n_d;
  logic a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0] n_ord;
  logic busy, accept, run, carry, last, io_last, div_add, mv_bc, mv_cb, shl_c;
  assign carry = carry_out_from_au;
  assign n_ord = 3'(order_add_from_op) + 3'(order_sub_from_op) + 3'(order_mul_from_op)
               + 3'(order_div_from_op) + 3'(order_and_from_op) + 3'(order_io_from_io);
  assign busy = st_q != IDLE;
  assign accept = !busy && n_ord == 3'd1;
  // a pu clear aborts the pending state, so every FSM pulse is gated by run
  assign run = !clear_a_from_pu;
  assign last = int'(cnt_q) == WIDTH - 1;
  assign io_last = int'(cnt_q) == int'(n_q) - 1;
  assign div_add = carry != reg_b0_from_au;
  assign mv_bc = run && (st_q == ADD_MV || st_q == SUB_MV || st_q == MUL_MV);
  assign mv_cb = run && (st_q == DIV_MV || st_q == AND_MV);
  assign shl_c = run && (st_q == DIV_SHL || st_q == IO_SH);
  assign au_busy_to_op = busy;
  assign order_error_to_op = n_ord > 3'd1 || (busy && n_ord != 3'd0);
  assign au_answer_to_op = mv_bc || mv_cb || (run && st_q == IO_DONE);
  assign overflow_to_op = run && carry && (st_q == ADD_SUM || st_q == DIV_CHK);
  assign do_clear_a_to_au = clear_a_from_pu;
  assign do_clear_b_to_au = run && st_q == MUL_INIT;
  assign do_not_a_to_au = run && (st_q == SUB_NOT || st_q == DIV_INIT || (st_q == SUB_CHK && !carry));
  assign do_not_b_to_au = run && st_q == SUB_CHK && !carry;
  assign do_sum_to_au = run && ((st_q == ADD_SUM && !carry) || (st_q == SUB_CHK && carry) || st_q == SUB_FIX
                      || (st_q == MUL_ADD && reg_c_lsb_from_au) || (st_q == DIV_SUM && div_add));
  assign do_and_to_au = run && st_q == AND_DO;
  assign do_set_c_lsb_to_au = run && st_q == DIV_SUM && div_add;
  assign do_left_shift_b_to_au = run && st_q == DIV_SHL;
  assign do_left_shift_c_to_au = shl_c;
  assign do_left_shift_c29_to_au = run && (st_q == DIV_SHL || (st_q == IO_SH && io_c29_from_io));
  assign do_right_shift_bc_to_au = run && st_q == MUL_SHR;
  assign do_move_c_to_a_to_au = move_c_to_a_from_pu;
  assign do_move_c_to_b_to_au = move_c_to_b_from_pu || mv_cb;
  assign do_move_b_to_c_to_au = move_b_to_c_from_pu || mv_bc;
  assign reg_a_sign_to_op = a_q;
  assign reg_b_sign_to_op = b_q;
  assign reg_b_sign_to_pu = b_q;
  assign write_sign_to_mem = c_q;
  assign output_sign_to_io = c_q;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    n_d = n_q;
    if (accept) begin
      cnt_d = '0;
      n_d = io_digits_from_io == '0 ? IO_W'(1) : io_digits_from_io;
      st_d = order_add_from_op ? ADD_SUM : order_sub_from_op ? SUB_NOT : order_mul_from_op ? MUL_INIT :
             order_div_from_op ? DIV_INIT : order_and_from_op ? AND_DO : IO_SH;
    end else begin
      case (st_q)
        ADD_SUM: st_d = carry ? IDLE : ADD_MV;
        SUB_NOT: st_d = SUB_CHK;
        SUB_CHK: st_d = carry ? SUB_MV : SUB_FIX;
        SUB_FIX: st_d = SUB_MV;
        MUL_INIT: st_d = MUL_ADD;
        MUL_ADD: st_d = MUL_SHR;
        MUL_SHR: begin
          cnt_d = cnt_q + CW'(1);
          st_d = last ? MUL_MV : MUL_ADD;
        end
        DIV_INIT: st_d = DIV_CHK;
        DIV_CHK: st_d = carry ? IDLE : DIV_SHL;
        DIV_SHL: st_d = DIV_SUM;
        DIV_SUM: begin
          cnt_d = cnt_q + CW'(1);
          st_d = last ? DIV_MV : DIV_SHL;
        end
        AND_DO: st_d = AND_MV;
        IO_SH: begin
          cnt_d = cnt_q + CW'(1);
          st_d = io_last ? IO_DONE : IO_SH;
        end
        default: st_d = IDLE;
      endcase
    end
    if (clear_a_from_pu) begin
      cnt_d = '0;
      st_d = busy ? IDLE : st_d;
    end
  end
  always_comb begin
    a_d = clear_a_from_pu ? 1'b0 : move_c_to_a_from_pu ? c_q && !ctrl_abs_from_op : a_q;
    b_d = move_c_to_b_from_pu ? c_q && !ctrl_abs_from_op : mv_cb ? c_q :
          (run && (st_q == MUL_INIT || st_q == DIV_INIT)) ? a_q ^ b_q :
          (run && st_q == SUB_CHK) ? b_q && !carry : do_clear_b_to_au ? 1'b0 : b_q;
    c_d = (move_b_to_c_from_pu || mv_bc) ? b_q : shl_c ? reg_c1_from_au :
          do_read_mem_from_mem ? read_sign_from_mem : do_arr_c_from_pnl ? arr_reg_c_sign_from_pnl : c_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      a_q <= 1'b0;
      b_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end
endmodule
